spoc_perm_sched: RTL and testbench



---
 rtl/spoc_pkg.sv | 21 ++
 rtl/spoc_rc_lfsr.sv | 25 ++
 rtl/spoc_perm_sched.sv | 123 ++++++++++++
 tb/tb_spoc_perm_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spoc_pkg.sv
// Shared types and constants for the SpoC-64 permutation scheduler.
package spoc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        MIX   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int STEPS_DEF  = 18;
    localparam int ROUNDS_DEF = 6;
    localparam int RC_WIDTH   = 6;
    localparam logic [RC_WIDTH-1:0] RC_INIT = 6'h01;

    // Fibonacci step: shift left, feed back rc[5]^rc[4] into bit 0.
    function automatic logic [RC_WIDTH-1:0] rc_next(input logic [RC_WIDTH-1:0] rc);
        return {rc[RC_WIDTH-2:0], rc[5] ^ rc[4]};
    endfunction

endpackage

// File: rtl/spoc_rc_lfsr.sv
// 6-bit round-constant LFSR for sLiSCP-light; clear has priority over load over advance.
module spoc_rc_lfsr
    import spoc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic                advance,
    output logic [RC_WIDTH-1:0] rc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc <= '0;
        end else if (clear) begin
            rc <= '0;
        end else if (load) begin
            rc <= RC_INIT;
        end else if (advance) begin
            rc <= rc_next(rc);
        end
    end

endmodule

// File: rtl/spoc_perm_sched.sv
// Round/step scheduler for the SpoC-64 permutation core.
// Optional abort input is built in when SPOC_PERM_ABORT_EN is defined.
module spoc_perm_sched
    import spoc_pkg::*;
#(
    parameter int STEPS           = STEPS_DEF,
    parameter int ROUNDS_PER_STEP = ROUNDS_DEF,
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int RW = (ROUNDS_PER_STEP > 1) ? $clog2(ROUNDS_PER_STEP) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hold,
`ifdef SPOC_PERM_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                en_round,
    output logic                en_mix,
    output logic                perm_done,
    output logic [RC_WIDTH-1:0] rc,
    output logic [SW-1:0]       step_idx,
    output logic [RW-1:0]       round_idx
);

    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS_PER_STEP - 1);

    state_t          state, state_nxt;
    logic [SW-1:0]   step_nxt;
    logic [RW-1:0]   round_nxt;
    logic            rc_load, rc_adv, rc_clr;
    logic            abort_req;

`ifdef SPOC_PERM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step_idx  <= '0;
            round_idx <= '0;
        end else begin
            state     <= state_nxt;
            step_idx  <= step_nxt;
            round_idx <= round_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step_idx;
        round_nxt = round_idx;
        rc_load   = 1'b0;
        rc_adv    = 1'b0;
        rc_clr    = 1'b0;
        en_round  = 1'b0;
        en_mix    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort_req) begin
                    state_nxt = ROUND;
                    rc_load   = 1'b1;
                    step_nxt  = '0;
                    round_nxt = '0;
                end
            end
            ROUND: begin
                if (!hold) begin
                    en_round = 1'b1;
                    rc_adv   = 1'b1;
                    if (round_idx == ROUND_LAST) begin
                        round_nxt = '0;
                        state_nxt = MIX;
                    end else begin
                        round_nxt = round_idx + RW'(1);
                    end
                end
            end
            MIX: begin
                if (!hold) begin
                    en_mix = 1'b1;
                    if (step_idx == STEP_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        step_nxt  = step_idx + SW'(1);
                        state_nxt = ROUND;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over hold and start: drop to IDLE with cleared constants.
        if (abort_req && state != IDLE) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            round_nxt = '0;
            rc_load   = 1'b0;
            rc_adv    = 1'b0;
            rc_clr    = 1'b1;
            en_round  = 1'b0;
            en_mix    = 1'b0;
        end
    end

    assign busy      = (state != IDLE);
    assign perm_done = (state == DONE);

    spoc_rc_lfsr u_rc (
        .clk     (clk),
        .rst     (rst),
        .clear   (rc_clr),
        .load    (rc_load),
        .advance (rc_adv),
        .rc      (rc)
    );

endmodule

// File: tb/tb_spoc_perm_sched.sv
// Self-checking bench for spoc_perm_sched: schedule-list reference model with random holds/starts.
module tb_spoc_perm_sched;

    localparam int STEPS = 18;
    localparam int RPS   = 6;

    logic       clk, rst, start, hold, start2, hold2;
    logic       busy, en_round, en_mix, perm_done;
    logic [5:0] rc;
    logic [4:0] step_idx;
    logic [2:0] round_idx;
    logic       busy2, en_round2, en_mix2, perm_done2;
    logic [5:0] rc2;
    logic [0:0] step_idx2, round_idx2;
`ifdef SPOC_PERM_ABORT_EN
    logic       abort, abort2;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         kind;   // 0 round, 1 mix, 2 done
        logic [5:0] rc;
        int         step;
        int         round;
    } ent_t;
    ent_t exp_q[$];

    spoc_perm_sched #(.STEPS(STEPS), .ROUNDS_PER_STEP(RPS)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
`ifdef SPOC_PERM_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .en_round(en_round), .en_mix(en_mix), .perm_done(perm_done),
        .rc(rc), .step_idx(step_idx), .round_idx(round_idx)
    );

    spoc_perm_sched #(.STEPS(2), .ROUNDS_PER_STEP(1)) u_small (
        .clk(clk), .rst(rst), .start(start2), .hold(hold2),
`ifdef SPOC_PERM_ABORT_EN
        .abort(abort2),
`endif
        .busy(busy2), .en_round(en_round2), .en_mix(en_mix2), .perm_done(perm_done2),
        .rc(rc2), .step_idx(step_idx2), .round_idx(round_idx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] lfsr_model(input logic [5:0] v);
        int x;
        x = int'(v);
        return 6'(((x * 2) % 64) + (((x / 32) + (x / 16)) % 2));
    endfunction

    // Expected timeline of one unheld permutation, one entry per cycle.
    task automatic build_sched(input int steps, input int rps);
        logic [5:0] r;
        r = 6'h01;
        exp_q.delete();
        for (int s = 0; s < steps; s++) begin
            for (int k = 0; k < rps; k++) begin
                exp_q.push_back('{0, r, s, k});
                r = lfsr_model(r);
            end
            exp_q.push_back('{1, r, s, 0});
        end
        exp_q.push_back('{2, r, steps - 1, 0});
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hold = 1'b0; start2 = 1'b0; hold2 = 1'b0;
`ifdef SPOC_PERM_ABORT_EN
        abort = 1'b0; abort2 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, en_round, en_mix, perm_done, rc, step_idx, round_idx} !== 18'h0) begin
            bad++;
            $display("FAIL reset_held got=%h exp=0", {busy, en_round, en_mix, perm_done, rc, step_idx, round_idx});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, perm_done, rc, step_idx, round_idx} !== 16'h0) begin
            bad++;
            $display("FAIL reset_release got=%h exp=0", {busy, perm_done, rc, step_idx, round_idx});
        end
        @(posedge clk); #1;
    endtask

    // mode 0: no hold, 1: hold in cycles 3-4, 2: random hold and start noise
    task automatic test_perm(input int mode);
        logic [5:0] rc_tab [6];
        logic [17:0] exp_v, act_v;
        ent_t e;
        int pos, cyc, held, done_cyc;
        logic h;
        rc_tab = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21};
        build_sched(STEPS, RPS);
        start = 1'b1; hold = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        pos = 0; cyc = 0; held = 0; done_cyc = -1;
        while (pos < exp_q.size() && cyc < 2000) begin
            cyc++;
            h = (mode == 1) ? (cyc == 3 || cyc == 4) :
                (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            hold  = h;
            start = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            @(negedge clk);
            e = exp_q[pos];
            exp_v = {1'b1, (e.kind == 0) && !h, (e.kind == 1) && !h, e.kind == 2,
                     e.rc, 5'(e.step), 3'(e.round)};
            act_v = {busy, en_round, en_mix, perm_done, rc, step_idx, round_idx};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL perm_m%0d cyc=%0d got=%h exp=%h", mode, cyc, act_v, exp_v);
            end
            if (mode == 0 && cyc <= 6) begin
                total++;
                if (rc !== rc_tab[cyc-1]) begin
                    bad++;
                    $display("FAIL rc_seq cyc=%0d got=%h exp=%h", cyc, rc, rc_tab[cyc-1]);
                end
            end
            if (mode == 1 && cyc >= 3 && cyc <= 5) begin
                total++;
                if (rc !== 6'h04) begin
                    bad++;
                    $display("FAIL rc_hold cyc=%0d got=%h exp=04", cyc, rc);
                end
            end
            if (e.kind == 2) done_cyc = cyc;
            if (!h || e.kind == 2) pos++;
            else held++;
            @(posedge clk); #1;
        end
        start = 1'b0; hold = 1'b0;
        total++;
        if (done_cyc !== 127 + held) begin
            bad++;
            $display("FAIL done_cycle_m%0d got=%0d exp=%0d", mode, done_cyc, 127 + held);
        end
        @(negedge clk);
        e = exp_q[exp_q.size() - 1];
        exp_v = {4'b0000, e.rc, 5'(STEPS - 1), 3'd0};
        act_v = {busy, en_round, en_mix, perm_done, rc, step_idx, round_idx};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL idle_after_m%0d got=%h exp=%h", mode, act_v, exp_v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc, seen;
        start = 1'b1; hold = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        for (cyc = 1; cyc <= 129; cyc++) begin
            start = (cyc == 50 || cyc == 127 || cyc == 128);
            @(negedge clk);
            if (cyc == 127) begin
                total++;
                if ({busy, perm_done} !== 2'b11) begin
                    bad++;
                    $display("FAIL b2b_done got=%b exp=11", {busy, perm_done});
                end
            end
            if (cyc == 128) begin
                total++;
                if ({busy, perm_done} !== 2'b00) begin
                    bad++;
                    $display("FAIL b2b_idle got=%b exp=00", {busy, perm_done});
                end
            end
            if (cyc == 129) begin
                total++;
                if ({en_round, rc, step_idx, round_idx} !== {1'b1, 6'h01, 5'd0, 3'd0}) begin
                    bad++;
                    $display("FAIL b2b_restart got=%h exp=%h", {en_round, rc, step_idx, round_idx},
                             {1'b1, 6'h01, 5'd0, 3'd0});
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        seen = -1;
        while (seen < 0 && cyc < 400) begin
            @(negedge clk);
            if (perm_done) seen = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (seen !== 128 + 127) begin
            bad++;
            $display("FAIL b2b_second_done got=%0d exp=%0d", seen, 128 + 127);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        start = 1'b1; hold = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (59) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        total++;
        if ({busy, en_round, en_mix, perm_done, rc, step_idx, round_idx} !== 18'h0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=0", {busy, en_round, en_mix, perm_done, rc, step_idx, round_idx});
        end
        @(posedge clk); #1; rst = 1'b0;
        seen = 0;
        repeat (140) begin
            @(negedge clk);
            if (perm_done || busy) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_no_done got=%0d exp=0", seen);
        end
        test_perm(0);
    endtask

    task automatic test_small();
        logic [11:0] exp_v, act_v;
        ent_t e;
        build_sched(2, 1);
        start2 = 1'b1; hold2 = 1'b0;
        @(posedge clk); #1; start2 = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc <= 5) begin
                e = exp_q[cyc-1];
                exp_v = {1'b1, e.kind == 0, e.kind == 1, e.kind == 2, e.rc, 1'(e.step), 1'(e.round)};
            end else begin
                exp_v = {4'b0000, 6'h04, 1'b1, 1'b0};
            end
            act_v = {busy2, en_round2, en_mix2, perm_done2, rc2, step_idx2, round_idx2};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL small cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef SPOC_PERM_ABORT_EN
    task automatic test_abort();
        int seen;
        start = 1'b1; hold = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        #1; hold = 1'b1; abort = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, en_round, en_mix} !== 3'b100) begin
            bad++;
            $display("FAIL abort_cycle got=%b exp=100", {busy, en_round, en_mix});
        end
        @(posedge clk); #1; abort = 1'b0; hold = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({busy, perm_done, rc, step_idx, round_idx} !== 16'h0) begin
                bad++;
                $display("FAIL abort_idle i=%0d got=%h exp=0", i, {busy, perm_done, rc, step_idx, round_idx});
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_perm(0);
        test_perm(1);
        test_perm(2);
        test_perm(2);
        test_back_to_back();
        test_reset_mid();
        test_small();
`ifdef SPOC_PERM_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
